// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and byte-level round functions.
// Byte k of a 128-bit block lives at [127-8k -: 8], column-major (k = row + 4*col).
package aes_pkg;

    localparam int unsigned NR_128      = 10;
    localparam logic [7:0]  KEY_LEN_128 = 8'd16;

    typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} aes_state_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Entry b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}.
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox(s[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 round-key step: previous round key plus rcon -> next round key.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rkey_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] nk_o
);

    logic [31:0] w0, w1, w2, w3, temp;

    always_comb begin
        // RotWord then SubWord on word 3, rcon folded into the leading byte.
        temp = {sbox(rkey_i[23:16]) ^ rcon_i, sbox(rkey_i[15:8]),
                sbox(rkey_i[7:0]), sbox(rkey_i[31:24])};
        w0   = rkey_i[127:96] ^ temp;
        w1   = rkey_i[95:64] ^ w0;
        w2   = rkey_i[63:32] ^ w1;
        w3   = rkey_i[31:0] ^ w2;
        nk_o = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/aes128_iter_enc.sv
// Iterative AES-128 encryptor: one round per clock, key schedule expanded on the fly.
module aes128_iter_enc
    import aes_pkg::*;
#(
    parameter int unsigned NR            = NR_128,
    parameter logic [7:0]  KEY_LEN_BYTES = KEY_LEN_128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   key_len,
    input  logic [127:0] i_data,
    input  logic [127:0] i_key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] o_data
);

    localparam logic [3:0] LastRnd = 4'(NR);

    aes_state_e   state_q, state_d;
    logic [127:0] data_q, data_d, rkey_q, rkey_d, odata_q, odata_d;
    logic [127:0] nk, sr_sb;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d, err_q, err_d;

    aes_key_step u_key_step (
        .rkey_i (rkey_q),
        .rcon_i (rcon(rnd_q)),
        .nk_o   (nk)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rkey_q  <= '0;
            rnd_q   <= '0;
            odata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rkey_q  <= rkey_d;
            rnd_q   <= rnd_d;
            odata_q <= odata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start && key_len == KEY_LEN_BYTES) state_d = ROUND;
            ROUND: if (rnd_q == LastRnd) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_sb   = shift_rows(sub_bytes(data_q));
        data_d  = data_q;
        rkey_d  = rkey_q;
        rnd_d   = rnd_q;
        odata_d = odata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (key_len == KEY_LEN_BYTES) begin
                        data_d = i_data ^ i_key;
                        rkey_d = i_key;
                        rnd_d  = 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ROUND: begin
                rkey_d = nk;
                if (rnd_q != LastRnd) begin
                    data_d = mix_columns(sr_sb) ^ nk;
                    rnd_d  = rnd_q + 4'd1;
                end else begin
                    odata_d = sr_sb ^ nk;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q == ROUND);
        done   = done_q;
        err    = err_q;
        o_data = odata_q;
    end

endmodule

// File: tb/tb_aes128_iter_enc.sv
// Directed bench for aes128_iter_enc and aes_key_step using FIPS-197 vectors.
module tb_aes128_iter_enc;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   key_len = 8'd16;
    logic [127:0] i_data = '0;
    logic [127:0] i_key = '0;
    logic         busy, done, err;
    logic [127:0] o_data;
    logic [127:0] ks_rkey = '0;
    logic [7:0]   ks_rcon = '0;
    logic [127:0] ks_nk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int n, b;

    aes128_iter_enc dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .key_len (key_len),
        .i_data  (i_data),
        .i_key   (i_key),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .o_data  (o_data)
    );

    aes_key_step u_ks (
        .rkey_i (ks_rkey),
        .rcon_i (ks_rcon),
        .nk_o   (ks_nk)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ticks until done is seen (bounded); n = edges taken, bc = busy samples before done.
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
            if (busy === 1'b1) bc++;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_odata", o_data, 128'h0);
        tick();
        reset = 1'b1;
        tick();

        // Test 6: key step unit
        ks_rkey = B_KEY;
        ks_rcon = 8'h01;
        #1;
        check("keystep_nk", ks_nk, B_RK1);

        // Test 1 + 4: C.1 with an ignored start at cycle 4
        key_len = 8'd16;
        i_data  = C1_PT;
        i_key   = C1_KEY;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_e0", 128'(busy), 128'(1));
        tick(); tick(); tick();
        i_data = B_PT;
        i_key  = 128'hdeadbeef_00000000_cafef00d_12345678;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy", 128'(busy), 128'(1));
        check("t4_err", 128'(err), 128'(0));
        wait_done(n, b);
        check("t1_latency", 128'(n + 4), 128'(10));
        check("t1_odata", o_data, C1_CT);
        check("t1_busy_done", 128'(busy), 128'(0));
        check("t1_err_done", 128'(err), 128'(0));

        // Test 2: back-to-back start in the done cycle
        i_data = B_PT;
        i_key  = B_KEY;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("t4_one_done", 128'(done_cnt), 128'(1));
        check("t2_busy_e0", 128'(busy), 128'(1));
        check("t2_done_low", 128'(done), 128'(0));
        check("t2_hold_prev", o_data, C1_CT);
        wait_done(n, b);
        check("t2_latency", 128'(n), 128'(10));
        check("t2_busy_cycles", 128'(b + 1), 128'(10));
        check("t2_odata", o_data, B_CT);
        tick();
        check("t2_done_pulse", 128'(done), 128'(0));
        check("t2_done_cnt", 128'(done_cnt), 128'(2));

        // Test 3: rejected key length
        key_len = 8'd24;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("t3_err", 128'(err), 128'(1));
        check("t3_busy", 128'(busy), 128'(0));
        check("t3_done", 128'(done), 128'(0));
        tick();
        check("t3_err_pulse", 128'(err), 128'(0));
        check("t3_busy2", 128'(busy), 128'(0));
        check("t3_odata", o_data, B_CT);
        key_len = 8'd16;

        // Test 5: asynchronous reset at round 5
        i_data = C1_PT;
        i_key  = C1_KEY;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_done", 128'(done), 128'(0));
        check("t5_err", 128'(err), 128'(0));
        check("t5_odata", o_data, 128'h0);
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("t5_no_done", 128'(done_cnt), 128'(2));
        check("t5_idle", 128'(busy), 128'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n, b);
        check("t5_latency", 128'(n), 128'(10));
        check("t5_odata", o_data, C1_CT);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_iter_enc.md
Name: aes128_iter_enc

Overview:
Iterative AES-128 encryption engine, one round per clock, with the key schedule computed on the fly. It sits directly downstream of the AES SPI driver. The driver hands it the plaintext field, key-length byte and key field of each received frame, and takes the ciphertext back to load into the slave's transmit register. It replaces the fully combinational cipher path with a start/busy/done handshake.

Parameters:
NR, 10, number of rounds; fixed for AES-128, not overridable in practice.
KEY_LEN_BYTES, 8'd16, the only key-length code accepted on key_len.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous active-low reset (0 = reset asserted).
start  input  1  request; sampled on rising clk edges only while idle.
key_len  input  8  frame key-length byte; 16 accepted, anything else rejected.
i_data  input  128  plaintext; [127:120] is state byte 0, column-major per FIPS-197.
i_key  input  128  cipher key, same byte order.
busy  output  1  high while rounds are in progress.
done  output  1  one-cycle pulse; o_data valid from this cycle.
err  output  1  one-cycle pulse when a start is rejected for key_len.
o_data  output  128  ciphertext; holds its value until the next successful completion.

Behaviour:
- Reset (reset=0, asynchronous): state returns to IDLE. busy=0, done=0, err=0, o_data=0. The internal state register, round key and round counter are all cleared.
- Reset mid-operation aborts the encryption with no done pulse. The result is discarded.
- States: IDLE and ROUND.
- IDLE, start=1 and key_len=16:
  - state_reg <= i_data ^ i_key; rkey <= i_key; rnd <= 1.
  - Go to ROUND; busy goes high on the same edge.
  - i_data and i_key are captured at this edge only, so later changes on them have no effect.
- IDLE, start=1 and key_len!=16: err=1 for exactly one cycle; stay in IDLE; o_data unchanged.
- IDLE, start=0: hold.
- ROUND, every edge:
  - nk = key_step(rkey, rcon[rnd]), where key_step is RotWord, SubWord and the rcon XOR on word 3, followed by the cascaded XOR into words 0..3.
  - rnd < NR: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ nk; rkey <= nk; rnd <= rnd+1.
  - rnd == NR: MixColumns is skipped; the result is written directly to o_data. done=1 and busy=0 for one cycle; return to IDLE.
- rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. rnd is a 4-bit counter and never wraps past NR.
- Latency: start is sampled at edge E0; the final round is at edge E10. done is high during the cycle after E10, so 10 cycles from start to result.
- start asserted while busy is ignored; it is not queued and does not raise err.
- start asserted in the done cycle is legal, because the FSM is already in IDLE. It is accepted for back-to-back operation, and o_data keeps the previous result until the next done.
- done and err are never high in the same cycle.
- GF(2^8) arithmetic uses xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0), truncated to 8 bits.

Decomposition:
- Package aes_pkg:
  - sbox lookup function (256-entry table) and xtime function.
  - rcon table indexed 1..10.
  - NR_128 = 10 and KEY_LEN_128 = 8'd16.
  - State encoding constants IDLE and ROUND.
- Sub-module aes_key_step: combinational next-round-key generator (rkey, rcon) -> nk. It is separately unit-testable against the FIPS-197 key expansion words.
- SubBytes, ShiftRows and MixColumns are functions in the package, instantiated inline in the engine.

Test Plan:
1. FIPS-197 C.1 vector.
   - Stimulus: key_len=16, i_data=00112233445566778899aabbccddeeff, i_key=000102030405060708090a0b0c0d0e0f, 1-cycle start.
   - Response: done exactly 10 cycles after the start edge; o_data=69c4e0d86a7b0430d8cdb78070b4c55a; busy high for 10 cycles.
2. FIPS-197 Appendix B vector, back-to-back with test 1.
   - Stimulus: i_data=3243f6a8885a308d313198a2e0370734, i_key=2b7e151628aed2a6abf7158809cf4f3c, start asserted in the done cycle of test 1.
   - Response: accepted; o_data=3925841d02dc09fbdc118597196a0b32 ten cycles later.
3. Rejected key length.
   - Stimulus: key_len=24, start=1.
   - Response: err=1 for one cycle; busy stays 0; no done; o_data keeps the previous result.
4. start while busy.
   - Stimulus: pulse start again at cycle 4 of test 1, with different inputs.
   - Response: ignored; the C.1 result is unchanged; exactly one done.
5. Reset mid-operation.
   - Stimulus: drive reset=0 asynchronously between edges at round 5.
   - Response: busy, done, err and o_data go to 0 immediately; no done after release. A fresh C.1 run then passes.
6. aes_key_step unit test.
   - Stimulus: rkey=2b7e151628aed2a6abf7158809cf4f3c, rcon=01.
   - Response: nk=a0fafe1788542cb123a339392a6c7605.
